noc_link_receiver: RTL and testbench
====================================

# noc_link_receiver

Receive-side endpoint of the credit-based router-to-router link. It buffers incoming flits (`data`/`dest`/`is_tail`/`send`) in a FIFO of `FLIT_BUFFER_DEPTH` entries and presents them on a valid/ready output. It returns one `credit_out` pulse per consumed flit and checks the link protocol: buffer overflow, destination consistency within a packet, and a packet counter. It sits at the far end of a router output port, for example at a NoC edge, a pipeline-link terminus or a test sink, and mirrors the router's sender-side credit counter.

## Interface
- `FLIT_WIDTH`, 64, width of the flit payload.
- `DEST_WIDTH`, 6, width of dest (TDEST+TID).
- `FLIT_BUFFER_DEPTH`, 2, FIFO entries; equals the sender's initial credit count; must be ≥1.
- `PKT_CNT_WIDTH`, 16, width of the packet counter.

Ports:
- `clk_noc`  in  1  NoC clock; the only clock.
- `rst_noc`  in  1  asynchronous, active-high reset.
- `data_in`  in  `FLIT_WIDTH`  flit payload.
- `dest_in`  in  `DEST_WIDTH`  flit destination.
- `is_tail_in`  in  1  last flit of the packet.
- `send_in`  in  1  flit valid this cycle.
- `credit_out`  out  1  one-cycle pulse returning one credit to the sender.
- `out_valid`  out  1  head of FIFO valid.
- `out_ready`  in  1  consumer accepts the head.
- `out_data`  out  `FLIT_WIDTH`  head payload.
- `out_dest`  out  `DEST_WIDTH`  head dest.
- `out_tail`  out  1  head is_tail.
- `overflow`  out  1  sticky; a flit arrived with no free entry.
- `dest_error`  out  1  sticky; a body or tail flit's dest differed from its head flit's dest.
- `in_packet`  out  1  input FSM is in state IN_PKT.
- `pkt_count`  out  `PKT_CNT_WIDTH`  accepted tail flits, modulo 2^`PKT_CNT_WIDTH`.

## Operation
- **Storage:** circular buffer with read/write pointers that wrap at `FLIT_BUFFER_DEPTH`, which need not be a power of two. An occupancy counter runs 0..DEPTH.
- **Push:** occurs when `send_in`=1 and either occupancy < DEPTH, or occupancy = DEPTH with a pop in the same cycle.
- **Drop:** `send_in`=1 with occupancy = DEPTH and no pop. The flit is discarded and `overflow` is set. Pointers, occupancy, FSM and `pkt_count` are unchanged.
- **Pop:** `out_valid & out_ready`. The read pointer advances. `credit_out` is registered and asserts for exactly one cycle on the next clock edge, one pulse per pop.
- **Output:** `out_*` are driven combinationally from the entry at the read pointer. `out_valid` = (occupancy ≠ 0). When `out_valid`=0, `out_*` are don't-care and the bench must not check them.
- **Simultaneous push and pop:** occupancy is unchanged and both pointers advance.
- **Input FSM (accepted flits only):**
  - IDLE: latch `dest_in` as head_dest. If `is_tail_in`=0, go to IN_PKT. If `is_tail_in`=1 (single-flit packet), stay in IDLE and increment `pkt_count`.
  - IN_PKT: if `dest_in` ≠ head_dest, set `dest_error`; the flit is still stored. If `is_tail_in`=1, go to IDLE and increment `pkt_count`.
- **Sticky flags:** `overflow` and `dest_error` clear only on reset.

## Timing
- **Reset values:** `credit_out`=0, `out_valid`=0, `overflow`=0, `dest_error`=0, `in_packet`=0, `pkt_count`=0. Pointers and occupancy are 0 and the FSM is in IDLE. Storage contents are not reset.
- **Reset mid-packet:** all buffered flits are discarded. No credits are returned for them; the sender is expected to be reset alongside.
- **Input to output latency:** a flit with `send_in` at edge N gives `out_valid`=1 after edge N, i.e. in cycle N+1, if the FIFO was empty.
- **Pop to credit latency:** a pop in cycle N gives `credit_out`=1 in cycle N+1 only.
- **Throughput:** one flit per cycle sustained with `out_ready`=1. A sender with DEPTH credits plus the 1-cycle credit return never overflows when DEPTH ≥ 2. DEPTH=1 supports one flit every 2+ cycles.
- **Flag and counter updates:** `in_packet`, `pkt_count` and the flags update on the edge that accepts or drops the flit.

## Test plan
- **Single flit:** after reset, send one flit (dest=0x15, data=0xA5A5…, tail=1) with `out_ready`=1. Expect `out_valid` for 1 cycle with the matching `out_*`, then `credit_out` pulsing once the cycle after the pop, and `pkt_count`=1 with `in_packet`=0.
- **Fill, then drain:** with DEPTH=2 and `out_ready`=0, send 2 flits of one packet (tail on the 2nd). Expect occupancy full and no credits. Raise `out_ready`. Expect the flits in order and 2 credit pulses on consecutive cycles.
- **Overflow:** with the FIFO full and `out_ready`=0, assert a 3rd `send_in`. Expect `overflow`=1 and sticky, and the dropped flit never appears at the output. Also check that a 3rd send in the same cycle as a pop is accepted with no overflow.
- **Destination error:** send a head with dest=3, then a body with dest=5, then a tail with dest=3. Expect `dest_error`=1 after the body flit, all 3 flits delivered, and `pkt_count` incremented by 1.
- **Streaming and wrap:** send 1000 back-to-back flits in 4-flit packets with DEPTH=3, where `out_ready` toggles pseudo-randomly and the sender honours credits. Expect no overflow, data in order, total credits = 1000, and `pkt_count`=250.
- **Reset mid-packet:** after the head flit plus one body flit are buffered, assert `rst_noc` asynchronously. Expect all outputs at their reset values immediately, and a fresh packet afterwards to be received correctly.

Source files
------------

// File: rtl/noc_link_receiver.sv
// noc_link_receiver: receive endpoint of a credit-based NoC link.
// Buffers flits, returns credits on pop, checks packet protocol.
module noc_link_receiver #(
  parameter int FLIT_WIDTH        = 64,
  parameter int DEST_WIDTH        = 6,
  parameter int FLIT_BUFFER_DEPTH = 2,
  parameter int PKT_CNT_WIDTH     = 16
) (
  input  logic                     clk_noc,
  input  logic                     rst_noc,
  input  logic [FLIT_WIDTH-1:0]    data_in,
  input  logic [DEST_WIDTH-1:0]    dest_in,
  input  logic                     is_tail_in,
  input  logic                     send_in,
  output logic                     credit_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [FLIT_WIDTH-1:0]    out_data,
  output logic [DEST_WIDTH-1:0]    out_dest,
  output logic                     out_tail,
  output logic                     overflow,
  output logic                     dest_error,
  output logic                     in_packet,
  output logic [PKT_CNT_WIDTH-1:0] pkt_count
);

  localparam int PW =
    (FLIT_BUFFER_DEPTH > 1) ? $clog2(FLIT_BUFFER_DEPTH) : 1;
  localparam int CW = $clog2(FLIT_BUFFER_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(FLIT_BUFFER_DEPTH);
  localparam logic [PW-1:0] LAST = PW'(FLIT_BUFFER_DEPTH - 1);

  typedef enum logic {
    IDLE,
    IN_PKT
  } state_t;

  logic [FLIT_WIDTH-1:0] mem_data [FLIT_BUFFER_DEPTH];
  logic [DEST_WIDTH-1:0] mem_dest [FLIT_BUFFER_DEPTH];
  logic                  mem_tail [FLIT_BUFFER_DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] occ;

  logic pop;
  logic push;
  logic drop;

  state_t                state_q;
  state_t                state_d;
  logic [DEST_WIDTH-1:0] head_q;
  logic [DEST_WIDTH-1:0] head_d;
  logic                  pc_inc;
  logic                  derr_set;

  assign out_valid = (occ != '0);
  assign pop       = out_valid & out_ready;
  // A full buffer still accepts when the head leaves this cycle.
  assign push      = send_in & ((occ != FULL) | pop);
  assign drop      = send_in & ~push;

  assign out_data  = mem_data[rd_ptr];
  assign out_dest  = mem_dest[rd_ptr];
  assign out_tail  = mem_tail[rd_ptr];
  assign in_packet = (state_q == IN_PKT);

  // Flit storage; contents are not reset.
  always_ff @(posedge clk_noc) begin
    if (push) begin
      mem_data[wr_ptr] <= data_in;
      mem_dest[wr_ptr] <= dest_in;
      mem_tail[wr_ptr] <= is_tail_in;
    end
  end

  // Pointers wrap at DEPTH (not necessarily a power of two).
  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      if (push && !pop)      occ <= occ + CW'(1);
      else if (pop && !push) occ <= occ - CW'(1);
    end
  end

  // One credit pulse per consumed flit, one cycle later.
  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) credit_out <= 1'b0;
    else         credit_out <= pop;
  end

  // Packet FSM state and head destination register.
  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      state_q <= IDLE;
      head_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
    end
  end

  // Packet FSM next state; only accepted flits advance it.
  always_comb begin
    state_d  = state_q;
    head_d   = head_q;
    pc_inc   = 1'b0;
    derr_set = 1'b0;
    if (push) begin
      unique case (state_q)
        IDLE: begin
          head_d = dest_in;
          if (is_tail_in) pc_inc  = 1'b1;
          else            state_d = IN_PKT;
        end
        IN_PKT: begin
          derr_set = (dest_in != head_q);
          if (is_tail_in) begin
            state_d = IDLE;
            pc_inc  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Sticky protocol flags and the packet counter.
  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      overflow   <= 1'b0;
      dest_error <= 1'b0;
      pkt_count  <= '0;
    end else begin
      if (drop)     overflow   <= 1'b1;
      if (derr_set) dest_error <= 1'b1;
      if (pc_inc)   pkt_count  <= pkt_count + PKT_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_noc_link_receiver.sv
// tb_noc_link_receiver: directed bench with a scoreboard model.
// Instance 0 has DEPTH=2, instance 1 has DEPTH=3 (streaming).
module tb_noc_link_receiver;

  typedef struct packed {
    logic [63:0] data;
    logic [5:0]  dest;
    logic        tail;
  } flit_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        snd [2];
  logic        rdy [2];
  logic        tl  [2];
  logic [63:0] dat [2];
  logic [5:0]  dst [2];

  logic        o_cr  [2];
  logic        o_v   [2];
  logic [63:0] o_d   [2];
  logic [5:0]  o_de  [2];
  logic        o_t   [2];
  logic        o_ovf [2];
  logic        o_der [2];
  logic        o_inp [2];
  logic [15:0] o_pc  [2];

  noc_link_receiver #(.FLIT_BUFFER_DEPTH(2)) u_d2 (
    .clk_noc(clk), .rst_noc(rst),
    .data_in(dat[0]), .dest_in(dst[0]),
    .is_tail_in(tl[0]), .send_in(snd[0]),
    .credit_out(o_cr[0]), .out_valid(o_v[0]),
    .out_ready(rdy[0]), .out_data(o_d[0]),
    .out_dest(o_de[0]), .out_tail(o_t[0]),
    .overflow(o_ovf[0]), .dest_error(o_der[0]),
    .in_packet(o_inp[0]), .pkt_count(o_pc[0])
  );

  noc_link_receiver #(.FLIT_BUFFER_DEPTH(3)) u_d3 (
    .clk_noc(clk), .rst_noc(rst),
    .data_in(dat[1]), .dest_in(dst[1]),
    .is_tail_in(tl[1]), .send_in(snd[1]),
    .credit_out(o_cr[1]), .out_valid(o_v[1]),
    .out_ready(rdy[1]), .out_data(o_d[1]),
    .out_dest(o_de[1]), .out_tail(o_t[1]),
    .overflow(o_ovf[1]), .dest_error(o_der[1]),
    .in_packet(o_inp[1]), .pkt_count(o_pc[1])
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: log of accepted flits, push/pop totals, flag state.
  int    depth [2] = '{2, 3};
  flit_t lg    [2][2048];
  int    np    [2] = '{0, 0};
  int    npp   [2] = '{0, 0};
  bit    ecr   [2] = '{0, 0};
  bit    eovf  [2] = '{0, 0};
  bit    ederr [2] = '{0, 0};
  bit    einp  [2] = '{0, 0};
  logic [5:0] hd [2] = '{6'd0, 6'd0};
  int    epc   [2] = '{0, 0};

  // Model update from the spec rules on each accepting edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        npp[i]   <= np[i];
        ecr[i]   <= 1'b0;
        eovf[i]  <= 1'b0;
        ederr[i] <= 1'b0;
        einp[i]  <= 1'b0;
        epc[i]   <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        automatic int occ = np[i] - npp[i];
        automatic bit pp = (occ != 0) && rdy[i];
        automatic bit ps = snd[i] && (occ < depth[i] || pp);
        ecr[i] <= pp;
        if (pp) npp[i] <= npp[i] + 1;
        if (snd[i] && !ps) eovf[i] <= 1'b1;
        if (ps) begin
          lg[i][np[i]] <= '{dat[i], dst[i], tl[i]};
          np[i] <= np[i] + 1;
          if (!einp[i]) begin
            hd[i] <= dst[i];
            if (tl[i]) epc[i] <= epc[i] + 1;
            else       einp[i] <= 1'b1;
          end else begin
            if (dst[i] != hd[i]) ederr[i] <= 1'b1;
            if (tl[i]) begin
              einp[i] <= 1'b0;
              epc[i]  <= epc[i] + 1;
            end
          end
        end
      end
    end
  end

  // Compare DUT against model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        automatic bit v = (np[i] != npp[i]);
        chk($sformatf("valid%0d", i), 64'(o_v[i]), 64'(v));
        if (v && o_v[i]) begin
          chk($sformatf("data%0d", i), o_d[i], lg[i][npp[i]].data);
          chk($sformatf("dest%0d", i), 64'(o_de[i]),
              64'(lg[i][npp[i]].dest));
          chk($sformatf("tail%0d", i), 64'(o_t[i]),
              64'(lg[i][npp[i]].tail));
        end
        chk($sformatf("credit%0d", i), 64'(o_cr[i]), 64'(ecr[i]));
        chk($sformatf("ovf%0d", i), 64'(o_ovf[i]), 64'(eovf[i]));
        chk($sformatf("derr%0d", i), 64'(o_der[i]), 64'(ederr[i]));
        chk($sformatf("inpkt%0d", i), 64'(o_inp[i]), 64'(einp[i]));
        chk($sformatf("pcnt%0d", i), 64'(o_pc[i]),
            64'(16'(epc[i])));
      end
    end
  end

  task automatic drv(input int i, input bit s, input logic [63:0] d,
                     input logic [5:0] de, input bit t, input bit r);
    @(negedge clk);
    snd[i] = s;
    dat[i] = d;
    dst[i] = de;
    tl[i]  = t;
    rdy[i] = r;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      snd[i] = 1'b0; rdy[i] = 1'b0; tl[i] = 1'b0;
      dat[i] = '0;   dst[i] = '0;
    end
    #2 rst = 1'b1;
    #1 chk_en = 1'b1;
    chk("rst_valid", 64'(o_v[0]), 64'd0);
    chk("rst_pcnt", 64'(o_pc[0]), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // single flit
    drv(0, 1, 64'hA5A5A5A5A5A5A5A5, 6'h15, 1, 1);
    drv(0, 0, 64'h0, 6'h0, 0, 1);
    chk("t1_valid", 64'(o_v[0]), 64'd1);
    chk("t1_data", o_d[0], 64'hA5A5A5A5A5A5A5A5);
    chk("t1_dest", 64'(o_de[0]), 64'h15);
    chk("t1_cr0", 64'(o_cr[0]), 64'd0);
    drv(0, 0, 64'h0, 6'h0, 0, 1);
    chk("t1_cr1", 64'(o_cr[0]), 64'd1);
    chk("t1_novalid", 64'(o_v[0]), 64'd0);
    chk("t1_pcnt", 64'(o_pc[0]), 64'd1);
    chk("t1_inpkt", 64'(o_inp[0]), 64'd0);
    drv(0, 0, 64'h0, 6'h0, 0, 1);
    chk("t1_cr_once", 64'(o_cr[0]), 64'd0);

    // fill then drain
    drv(0, 1, 64'hF1, 6'h04, 0, 0);
    drv(0, 1, 64'hF2, 6'h04, 1, 0);
    drv(0, 0, 64'h0, 6'h0, 0, 0);
    chk("t2_full_valid", 64'(o_v[0]), 64'd1);
    chk("t2_head", o_d[0], 64'hF1);
    drv(0, 0, 64'h0, 6'h0, 0, 1);
    chk("t2_nocredit", 64'(o_cr[0]), 64'd0);
    drv(0, 0, 64'h0, 6'h0, 0, 1);
    chk("t2_second", o_d[0], 64'hF2);
    chk("t2_cr_a", 64'(o_cr[0]), 64'd1);
    drv(0, 0, 64'h0, 6'h0, 0, 1);
    chk("t2_cr_b", 64'(o_cr[0]), 64'd1);
    chk("t2_pcnt", 64'(o_pc[0]), 64'd2);

    // full buffer, send together with a pop
    drv(0, 1, 64'h61, 6'h0A, 0, 0);
    drv(0, 1, 64'h62, 6'h0A, 0, 0);
    drv(0, 1, 64'h63, 6'h0A, 1, 1);
    drv(0, 0, 64'h0, 6'h0, 0, 1);
    chk("t3_noovf", 64'(o_ovf[0]), 64'd0);
    repeat (3) drv(0, 0, 64'h0, 6'h0, 0, 1);
    chk("t3_pcnt", 64'(o_pc[0]), 64'd3);

    // overflow
    drv(0, 1, 64'h71, 6'h09, 0, 0);
    drv(0, 1, 64'h72, 6'h09, 1, 0);
    drv(0, 1, 64'hDEAD, 6'h09, 1, 0);
    drv(0, 0, 64'h0, 6'h0, 0, 0);
    chk("t4_ovf", 64'(o_ovf[0]), 64'd1);
    chk("t4_pcnt", 64'(o_pc[0]), 64'd4);
    chk("t4_inpkt", 64'(o_inp[0]), 64'd0);
    repeat (4) drv(0, 0, 64'h0, 6'h0, 0, 1);
    chk("t4_sticky", 64'(o_ovf[0]), 64'd1);
    chk("t4_empty", 64'(o_v[0]), 64'd0);

    // destination error
    chk("t5_derr0", 64'(o_der[0]), 64'd0);
    drv(0, 1, 64'hD1, 6'h03, 0, 1);
    drv(0, 1, 64'hD2, 6'h05, 0, 1);
    chk("t5_derr_head", 64'(o_der[0]), 64'd0);
    drv(0, 1, 64'hD3, 6'h03, 1, 1);
    chk("t5_derr_body", 64'(o_der[0]), 64'd1);
    repeat (3) drv(0, 0, 64'h0, 6'h0, 0, 1);
    chk("t5_pcnt", 64'(o_pc[0]), 64'd5);

    // reset mid-packet
    drv(0, 1, 64'hB1, 6'h02, 0, 0);
    drv(0, 1, 64'hB2, 6'h02, 0, 0);
    drv(0, 0, 64'h0, 6'h0, 0, 0);
    chk("t6_inpkt", 64'(o_inp[0]), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_valid", 64'(o_v[0]), 64'd0);
    chk("t6_inp", 64'(o_inp[0]), 64'd0);
    chk("t6_pc", 64'(o_pc[0]), 64'd0);
    chk("t6_ovf", 64'(o_ovf[0]), 64'd0);
    chk("t6_der", 64'(o_der[0]), 64'd0);
    chk("t6_cr", 64'(o_cr[0]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    drv(0, 1, 64'hC1, 6'h08, 0, 1);
    drv(0, 1, 64'hC2, 6'h08, 1, 1);
    chk("t6_fresh", o_d[0], 64'hC1);
    repeat (3) drv(0, 0, 64'h0, 6'h0, 0, 1);
    chk("t6_pcnt", 64'(o_pc[0]), 64'd1);

    // streaming with credits on DEPTH=3
    begin
      int sent = 0;
      int cr   = 3;
      int crs  = 0;
      int cyc  = 0;
      while ((sent < 1000 || crs < 1000) && cyc < 20000) begin
        @(negedge clk);
        cyc++;
        if (o_cr[1]) begin
          cr++;
          crs++;
        end
        if (sent < 1000 && cr > 0) begin
          snd[1] = 1'b1;
          dat[1] = {32'hC0DE0000, 32'(sent)};
          dst[1] = 6'((sent / 4) % 64);
          tl[1]  = ((sent % 4) == 3);
          cr--;
          sent++;
        end else begin
          snd[1] = 1'b0;
        end
        rdy[1] = 1'($urandom_range(0, 1));
      end
      chk("t7_timeout", 64'(cyc < 20000), 64'd1);
      chk("t7_credits", 64'(crs), 64'd1000);
      chk("t7_model_pushes", 64'(np[1]), 64'd1000);
      @(negedge clk);
      rdy[1] = 1'b0;
      chk("t7_pcnt", 64'(o_pc[1]), 64'd250);
      chk("t7_noovf", 64'(o_ovf[1]), 64'd0);
      chk("t7_noderr", 64'(o_der[1]), 64'd0);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
